// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic matrix-multiply datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   feeder_state_e  - memb_feeder FSM encoding (IDLE, LOAD, FULL, DRAIN)
//   elem_t          - signed A/B operand element at the default width
//   drain_cycles()  - shift cycles needed to push every skewed column of a
//                     DIM x DIM B tile into the array (2*DIM-1)
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

  localparam int ELEM_BITS = 8;

  typedef logic signed [ELEM_BITS-1:0] elem_t;

  // Skew depth of a DIM-wide buffer: the last column starts DIM-1 cycles
  // late and then needs DIM cycles of its own.
  function automatic int drain_cycles(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/memb_feeder.sv
// Loads DIM B rows into the memB skew buffer, then shifts it out 2*DIM-1 cycles.
// Latency: mem_wr_en/mem_bin one cycle after each accept; mem_en one cycle after entering DRAIN.
// Backpressure: in_ready drops in FULL and DRAIN; a presented row must be held until accepted.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - row handshake; in_row[c] is the element for column c
//   start               - begin the drain; only honoured in FULL
//   busy                - high in LOAD, FULL and DRAIN
//   done                - one-cycle pulse alongside the last mem_en cycle
//   mem_bin, mem_wr_en  - row data and write/shift strobe to the skew buffer
//   mem_en              - shift-only enable to the skew buffer
//
// Build option: define MEMB_FEEDER_AUTOSTART_EN to drain straight after the
// DIM-th row without waiting in FULL; start is then ignored.
// DIM must be at least 2.
module memb_feeder
  import tpu_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0] in_row,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic signed [DIM-1:0][BITS_AB-1:0] mem_bin,
  output logic                             mem_wr_en,
  output logic                             mem_en
);

  localparam int RC_W = $clog2(DIM + 1);
  localparam int DC_W = $clog2(2 * DIM);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_FULL  = FULL;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [RC_W-1:0] ROW_LAST   = RC_W'(DIM - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(drain_cycles(DIM) - 1);

  logic [1:0]      state;
  logic [RC_W-1:0] row_cnt;
  logic [DC_W-1:0] drain_cnt;
  logic            accept;

  assign in_ready = (state == ST_IDLE) || (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef MEMB_FEEDER_AUTOSTART_EN
  logic unused_start;
  assign unused_start = start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      drain_cnt <= '0;
      mem_wr_en <= 1'b0;
      mem_en    <= 1'b0;
      mem_bin   <= '0;
      done      <= 1'b0;
    end else begin
      // Strobes are single-cycle and mem_bin is only non-zero alongside a
      // write, so the skew buffer never sees stale data during gaps.
      mem_wr_en <= 1'b0;
      mem_en    <= 1'b0;
      mem_bin   <= '0;
      done      <= 1'b0;

      case (state)
        ST_IDLE, ST_LOAD: begin
          // row_cnt is zero on entry to IDLE, so IDLE and LOAD share one path.
          if (accept) begin
            mem_bin   <= in_row;
            mem_wr_en <= 1'b1;
            row_cnt   <= row_cnt + RC_W'(1);
            if (row_cnt == ROW_LAST) begin
`ifdef MEMB_FEEDER_AUTOSTART_EN
              state     <= ST_DRAIN;
              drain_cnt <= '0;
`else
              state     <= ST_FULL;
`endif
            end else begin
              state <= ST_LOAD;
            end
          end
        end

        ST_FULL: begin
`ifdef MEMB_FEEDER_AUTOSTART_EN
          // Not reachable in this build; fall through to the drain anyway.
          state     <= ST_DRAIN;
          drain_cnt <= '0;
`else
          if (start) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
`endif
        end

        ST_DRAIN: begin
          mem_en <= 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            done      <= 1'b1;
            state     <= ST_IDLE;
            drain_cnt <= '0;
            row_cnt   <= '0;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memb_feeder.sv
// Self-checking bench for memb_feeder at DIM=8, BITS_AB=8.
// Latency: n/a (bench).
// Backpressure: rows are held on in_row until the handshake completes.
module tb_memb_feeder;

  localparam int DIM = 8;
  localparam int BW  = 8;

`ifdef MEMB_FEEDER_AUTOSTART_EN
  localparam int D0 = 8;   // first cycle spent in DRAIN within the table
`else
  localparam int D0 = 10;
`endif

  typedef logic [DIM-1:0][BW-1:0] row_t;

  typedef struct {
    logic vld;
    logic strt;
    int   base;
    logic rdy;
    logic bsy;
    logic wr;
    logic en;
    logic dn;
    int   bin_base;   // -1: mem_bin must be zero
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  row_t in_row;
  logic start;
  logic busy;
  logic done;
  row_t mem_bin;
  logic mem_wr_en;
  logic mem_en;

  int n_cmp = 0;
  int n_bad = 0;

  memb_feeder #(.BITS_AB(BW), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_bin   (mem_bin),
    .mem_wr_en (mem_wr_en),
    .mem_en    (mem_en)
  );

  always #5 clk = ~clk;

  function automatic row_t mk_row(input int base);
    row_t r;
    for (int c = 0; c < DIM; c++) r[c] = BW'(base + c);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Passive monitor: write log, drain counters, per-cycle invariants.
  logic mon_on = 1'b0;
  row_t wr_q[$];
  int   en_cnt   = 0;
  int   done_cnt = 0;
  int   en_run   = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_wr_en) wr_q.push_back(mem_bin);
      if (mem_en) begin
        en_cnt++;
        en_run++;
      end else begin
        en_run = 0;
      end
      if (done) begin
        done_cnt++;
        chk("done_on_last_en", 64'(en_run), 64'd15);
      end
      chkb("wr_en_exclusive", mem_wr_en & mem_en, 1'b0);
      if (!mem_wr_en) chk("bin_zero_without_wr", mem_bin, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_rows(input int base0, input int n, input int gapsel);
    int gaps[8] = '{1, 0, 3, 2, 0, 1, 3, 2};
    for (int r = 0; r < n; r++) begin
      if (gapsel != 0) repeat (gaps[r]) tick();
      chkb("load_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_row   = mk_row(base0 + 8 * r);
      tick();
      in_valid = 1'b0;
      in_row   = '0;
      if (gapsel != 0 && r == 3) begin
        start = 1'b1;      // mid-load start must be ignored
        tick();
        start = 1'b0;
      end
    end
  endtask

  task automatic wait_done(input string nm, input logic chk_hold);
    logic seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (chk_hold) chkb("hold_not_ready", in_ready, 1'b0);
    end
    if (!seen) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  vec_t tbl[$];

  initial begin
    // Back-to-back load (element c of row r = 8r+c), start, full drain.
    for (int k = 0; k < D0 + 17; k++) begin
      vec_t v;
      v.vld      = (k < 8);
      v.base     = 8 * k;
`ifdef MEMB_FEEDER_AUTOSTART_EN
      v.strt     = 1'b0;
`else
      v.strt     = (k == 9);
`endif
      v.rdy      = (k < 8) || (k > D0 + 14);
      v.bsy      = (k >= 1) && (k <= D0 + 14);
      v.wr       = (k >= 1) && (k <= 8);
      v.bin_base = v.wr ? 8 * (k - 1) : -1;
      v.en       = (k >= D0 + 1) && (k <= D0 + 15);
      v.dn       = (k == D0 + 15);
      tbl.push_back(v);
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_row   = '0;
    repeat (2) tick();
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_wr_en", mem_wr_en, 1'b0);
    chkb("rst_mem_en", mem_en, 1'b0);
    chkb("rst_done", done, 1'b0);
    chk("rst_mem_bin", mem_bin, 64'd0);
    rst    = 1'b0;
    mon_on = 1'b1;

    foreach (tbl[k]) begin
      tick();
      chkb($sformatf("v%0d_in_ready", k), in_ready, tbl[k].rdy);
      chkb($sformatf("v%0d_busy", k), busy, tbl[k].bsy);
      chkb($sformatf("v%0d_wr_en", k), mem_wr_en, tbl[k].wr);
      chkb($sformatf("v%0d_mem_en", k), mem_en, tbl[k].en);
      chkb($sformatf("v%0d_done", k), done, tbl[k].dn);
      chk($sformatf("v%0d_mem_bin", k), mem_bin,
          (tbl[k].bin_base < 0) ? 64'd0 : 64'(mk_row(tbl[k].bin_base)));
      in_valid = tbl[k].vld;
      in_row   = tbl[k].vld ? mk_row(tbl[k].base) : '0;
      start    = tbl[k].strt;
    end
    in_valid = 1'b0;
    in_row   = '0;
    start    = 1'b0;

`ifndef MEMB_FEEDER_AUTOSTART_EN
    // Gapped load with start pulsed in IDLE and after row 4.
    tick();
    wr_q.delete();
    en_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chkb("idle_start_busy", busy, 1'b0);
    chkb("idle_start_ready", in_ready, 1'b1);
    send_rows(8'h40, 8, 1);
    repeat (3) tick();
    chkb("full_ready", in_ready, 1'b0);
    chkb("full_busy", busy, 1'b1);
    chkb("full_no_shift", mem_en, 1'b0);
    chk("gap_wr_count", 64'(wr_q.size()), 64'd8);
    chk("early_start_no_drain", 64'(en_cnt), 64'd0);
    for (int r = 0; r < 8 && r < wr_q.size(); r++)
      chk($sformatf("gap_row%0d", r), wr_q[r], mk_row(8'h40 + 8 * r));

    // Row presented through FULL and DRAIN is held, then taken after done.
    in_valid = 1'b1;
    in_row   = mk_row(8'hA0);
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done("hold", 1'b1);
    chk("hold_not_consumed", 64'(wr_q.size()), 64'd8);
    chk("drain_len", 64'(en_cnt), 64'd15);
    chkb("done_cycle_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_row   = '0;
    chkb("held_row_wr", mem_wr_en, 1'b1);
    chk("held_row_data", mem_bin, mk_row(8'hA0));

    // Finish that matrix, then reset at drain cycle 6.
    send_rows(8'hA8, 7, 0);
    en_cnt = 0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && en_cnt < 6; i++) tick();
    chk("abort_point", 64'(en_cnt), 64'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("abort_mem_en", mem_en, 1'b0);
    chkb("abort_busy", busy, 1'b0);
    chkb("abort_ready", in_ready, 1'b1);
    chkb("abort_done", done, 1'b0);
    chk("abort_no_done", 64'(done_cnt), 64'd1);

    // Fresh load and drain after the abort.
    wr_q.delete();
    en_cnt   = 0;
    done_cnt = 0;
    send_rows(8'h10, 8, 0);
    chkb("reload_full", in_ready, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("reload", 1'b0);
    chk("reload_wr_count", 64'(wr_q.size()), 64'd8);
    chk("reload_drain_len", 64'(en_cnt), 64'd15);
    chk("reload_done_cnt", 64'(done_cnt), 64'd1);
    for (int r = 0; r < 8 && r < wr_q.size(); r++)
      chk($sformatf("reload_row%0d", r), wr_q[r], mk_row(8'h10 + 8 * r));
    tick();
    chkb("reload_idle_busy", busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
